// File: rtl/usb_rx.sv
// usb_rx: full-speed USB receiver. Line sync, bit recovery, NRZI,
// unstuffing, SYNC/PID/EOP framing, CRC16 check and payload stores.
module usb_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  input  logic [6:0] buffer_occupancy,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic       flush,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOP, S_ERR
  } state_t;

  state_t r_state;

  logic          r_dp_s1, r_dp_s2, r_dp_d;
  logic          r_dm_s1, r_dm_s2;
  logic [CW-1:0] r_cnt;
  logic          r_prev;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic [2:0]    r_ones;
  logic [1:0]    r_se0cnt;
  logic [1:0]    r_bcnt;
  logic          r_seen_se0;
  logic [2:0]    r_ptype;
  logic [15:0]   r_crc;
  logic [7:0]    r_d0, r_d1;

  logic       w_edge, w_sample, w_se0, w_j, w_kstart;
  logic       w_bit, w_stuff, w_err;
  logic [7:0] w_byte;
  logic [2:0] w_ptype;
  logic       w_pid_ok, w_is_tok, w_is_dat, w_full;

  assign w_edge   = r_dp_s2 ^ r_dp_d;
  assign w_sample = (r_cnt == HALF);
  assign w_se0    = !r_dp_s2 && !r_dm_s2;
  assign w_j      = r_dp_s2 && !r_dm_s2;
  assign w_kstart = w_edge && !r_dp_s2 && r_dm_s2;
  assign w_bit    = (r_dp_s2 == r_prev);
  assign w_stuff  = (r_ones == 3'd6);
  assign w_byte   = {w_bit, r_shift[7:1]};
  assign w_full   = (buffer_occupancy == 7'(MAX_PAYLOAD));

  function automatic logic [15:0] f_crc(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    w_ptype = 3'd0;
    case (w_byte[3:0])
      4'h1:    w_ptype = 3'd1;
      4'h9:    w_ptype = 3'd2;
      4'h3:    w_ptype = 3'd3;
      4'hB:    w_ptype = 3'd4;
      4'h2:    w_ptype = 3'd5;
      4'hA:    w_ptype = 3'd6;
      4'hE:    w_ptype = 3'd7;
      default: w_ptype = 3'd0;
    endcase
  end

  assign w_pid_ok = (w_byte[7:4] == ~w_byte[3:0]) && (w_ptype != 3'd0);
  assign w_is_tok = (w_ptype == 3'd1) || (w_ptype == 3'd2);
  assign w_is_dat = (w_ptype == 3'd3) || (w_ptype == 3'd4);

  // Error detection wins over any store or ready in the same sample.
  always_comb begin
    w_err = 1'b0;
    if (w_sample) begin
      case (r_state)
        S_SYNC, S_PID, S_TOKEN, S_DATA: begin
          if (w_se0)
            w_err = !((r_state == S_DATA) && (r_bitcnt == 3'd0));
          else if (w_stuff)
            w_err = w_bit;
          else if (r_bitcnt == 3'd7) begin
            if (r_state == S_SYNC)      w_err = (w_byte != 8'h80);
            else if (r_state == S_PID)  w_err = !w_pid_ok;
            else if (r_state == S_DATA) w_err = (r_bcnt == 2'd2) && w_full;
          end
        end
        S_EOP:   w_err = !w_se0 && !((r_se0cnt == 2'd2) && w_j);
        default: w_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dp_s1 <= 1'b1;
      r_dp_s2 <= 1'b1;
      r_dp_d  <= 1'b1;
      r_dm_s1 <= 1'b0;
      r_dm_s2 <= 1'b0;
      r_cnt   <= '0;
      r_prev  <= 1'b1;
    end else begin
      r_dp_s1 <= dplus_in;
      r_dp_s2 <= r_dp_s1;
      r_dp_d  <= r_dp_s2;
      r_dm_s1 <= dminus_in;
      r_dm_s2 <= r_dm_s1;
      if (w_edge || r_cnt == LAST) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 1'b1;
      if (w_sample) r_prev <= r_dp_s2;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state              <= S_IDLE;
      r_shift              <= '0;
      r_bitcnt             <= '0;
      r_ones               <= '0;
      r_se0cnt             <= '0;
      r_bcnt               <= '0;
      r_seen_se0           <= 1'b0;
      r_ptype              <= '0;
      r_crc                <= 16'hFFFF;
      r_d0                 <= '0;
      r_d1                 <= '0;
      rx_packet            <= '0;
      rx_data_ready        <= 1'b0;
      rx_transfer_active   <= 1'b0;
      rx_error             <= 1'b0;
      flush                <= 1'b0;
      store_rx_packet_data <= 1'b0;
      rx_packet_data       <= '0;
    end else begin
      flush                <= 1'b0;
      store_rx_packet_data <= 1'b0;
      rx_data_ready        <= 1'b0;
      if (w_err) begin
        r_state    <= S_ERR;
        rx_error   <= 1'b1;
        rx_packet  <= '0;
        r_seen_se0 <= w_se0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_kstart) begin
              r_state            <= S_SYNC;
              rx_transfer_active <= 1'b1;
              rx_error           <= 1'b0;
              rx_packet          <= '0;
              r_ones             <= '0;
              r_bitcnt           <= '0;
            end
          end
          S_ERR: begin
            if (w_sample) begin
              if (w_se0) r_seen_se0 <= 1'b1;
              else if (r_seen_se0 && w_j) begin
                rx_transfer_active <= 1'b0;
                r_state            <= S_IDLE;
              end
            end
          end
          S_EOP: begin
            if (w_sample) begin
              if (w_se0) begin
                if (r_se0cnt != 2'd2) r_se0cnt <= r_se0cnt + 2'd1;
              end else begin
                rx_transfer_active <= 1'b0;
                r_state            <= S_IDLE;
                if (r_ptype != 3'd3 && r_ptype != 3'd4) begin
                  rx_packet <= r_ptype;
                end else if (r_crc == 16'h800D && r_bcnt == 2'd2) begin
                  rx_packet     <= r_ptype;
                  rx_data_ready <= 1'b1;
                end else begin
                  rx_error  <= 1'b1;
                  rx_packet <= '0;
                end
              end
            end
          end
          default: begin
            if (w_sample) begin
              if (w_se0) begin
                r_state  <= S_EOP;
                r_se0cnt <= 2'd1;
              end else if (w_stuff) begin
                r_ones <= '0;
              end else begin
                r_ones   <= w_bit ? r_ones + 3'd1 : 3'd0;
                r_shift  <= w_byte;
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                  case (r_state)
                    S_SYNC: r_state <= S_PID;
                    S_PID: begin
                      r_ptype <= w_ptype;
                      r_bcnt  <= '0;
                      unique case (1'b1)
                        w_is_tok: r_state <= S_TOKEN;
                        w_is_dat: begin
                          r_state <= S_DATA;
                          flush   <= 1'b1;
                          r_crc   <= 16'hFFFF;
                        end
                        default: begin
                          r_state  <= S_EOP;
                          r_se0cnt <= '0;
                        end
                      endcase
                    end
                    S_TOKEN: begin
                      if (r_bcnt == 2'd1) begin
                        r_state  <= S_EOP;
                        r_se0cnt <= '0;
                      end else begin
                        r_bcnt <= r_bcnt + 2'd1;
                      end
                    end
                    S_DATA: begin
                      // Two-byte delay keeps the trailing CRC out of the FIFO.
                      r_crc <= f_crc(r_crc, w_byte);
                      r_d0  <= w_byte;
                      r_d1  <= r_d0;
                      if (r_bcnt == 2'd2) begin
                        store_rx_packet_data <= 1'b1;
                        rx_packet_data       <= r_d1;
                      end else begin
                        r_bcnt <= r_bcnt + 2'd1;
                      end
                    end
                    default: r_state <= S_ERR;
                  endcase
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: drives NRZI/stuffed line traffic into usb_rx and
// scoreboards payload stores and packet status.
module tb_usb_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       dplus_in = 1'b1;
  logic       dminus_in = 1'b0;
  logic [6:0] buffer_occupancy = '0;
  logic [2:0] rx_packet;
  logic       rx_data_ready, rx_transfer_active, rx_error;
  logic       flush, store_rx_packet_data;
  logic [7:0] rx_packet_data;

  usb_rx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .dplus_in             (dplus_in),
    .dminus_in            (dminus_in),
    .buffer_occupancy     (buffer_occupancy),
    .rx_packet            (rx_packet),
    .rx_data_ready        (rx_data_ready),
    .rx_transfer_active   (rx_transfer_active),
    .rx_error             (rx_error),
    .flush                (flush),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] pay_q[$];

  int store_cnt, ready_cnt, flush_cnt, flush_at;
  logic seen_active;
  logic lvl;
  int   ones;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (store_rx_packet_data) begin
        store_cnt++;
        if (exp_q.size() == 0)
          chk("store_unexpected", 32'(rx_packet_data), 32'hFFFF_FFFF);
        else
          chk("store_data", 32'(rx_packet_data), 32'(exp_q.pop_front()));
      end
      if (rx_data_ready) ready_cnt++;
      if (flush) begin
        flush_cnt++;
        flush_at = store_cnt;
      end
      if (rx_transfer_active) seen_active = 1'b1;
    end
  end

  task automatic clr();
    store_cnt   = 0;
    ready_cnt   = 0;
    flush_cnt   = 0;
    flush_at    = -1;
    seen_active = 1'b0;
  endtask

  task automatic hold(input logic dp, input logic dm);
    #1;
    dplus_in  = dp;
    dminus_in = dm;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (!b) lvl = ~lvl;
    hold(lvl, ~lvl);
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (d[i]) begin
        ones++;
        if (ones == 6) begin
          send_bit(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
  endtask

  task automatic send_head();
    lvl  = 1'b1;
    ones = 0;
    send_byte(8'h80);
    foreach (tx_q[k]) send_byte(tx_q[k]);
  endtask

  task automatic send_eop();
    hold(1'b0, 1'b0);
    hold(1'b0, 1'b0);
    hold(1'b1, 1'b0);
    lvl = 1'b1;
    repeat (4) hold(1'b1, 1'b0);
  endtask

  // Builds pid + pay_q + CRC16 (complemented, sent MSB of register first).
  task automatic load_data(input logic [7:0] pid, input logic flip,
                           input logic push);
    logic [15:0] c;
    logic [15:0] r;
    logic [7:0]  c0, c1;
    logic        fb;
    c = 16'hFFFF;
    foreach (pay_q[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = pay_q[k][i] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    r = ~c;
    for (int i = 0; i < 8; i++) begin
      c0[i] = r[15-i];
      c1[i] = r[7-i];
    end
    if (flip) c0[0] = ~c0[0];
    tx_q.delete();
    tx_q.push_back(pid);
    foreach (pay_q[k]) begin
      tx_q.push_back(pay_q[k]);
      if (push) exp_q.push_back(pay_q[k]);
    end
    tx_q.push_back(c0);
    tx_q.push_back(c1);
  endtask

  initial begin
    logic [7:0] b3;
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_packet", 32'(rx_packet), 0);
    chk("rst_outs", 32'({rx_data_ready, rx_transfer_active, rx_error,
                         flush, store_rx_packet_data}), 0);
    chk("rst_data", 32'(rx_packet_data), 0);
    #1 n_rst = 1'b1;
    repeat (4) hold(1'b1, 1'b0);

    // ACK handshake
    clr();
    tx_q = '{8'hD2};
    send_head();
    send_eop();
    chk("ack_packet", 32'(rx_packet), 5);
    chk("ack_ready", 32'(ready_cnt), 0);
    chk("ack_active_seen", 32'(seen_active), 1);
    chk("ack_active_end", 32'(rx_transfer_active), 0);
    chk("ack_error", 32'(rx_error), 0);

    // DATA0 with stuffed 0xFF
    clr();
    pay_q = '{8'hAB, 8'hFF, 8'h00};
    load_data(8'hC3, 1'b0, 1'b1);
    send_head();
    send_eop();
    chk("d0_stores", 32'(store_cnt), 3);
    chk("d0_pending", 32'(exp_q.size()), 0);
    chk("d0_flush", 32'(flush_cnt), 1);
    chk("d0_flush_first", 32'(flush_at), 0);
    chk("d0_packet", 32'(rx_packet), 3);
    chk("d0_ready", 32'(ready_cnt), 1);
    chk("d0_error", 32'(rx_error), 0);
    chk("d0_active", 32'(rx_transfer_active), 0);

    // Same packet with a corrupted CRC bit
    clr();
    load_data(8'hC3, 1'b1, 1'b1);
    send_head();
    send_eop();
    chk("bad_crc_stores", 32'(store_cnt), 3);
    chk("bad_crc_pending", 32'(exp_q.size()), 0);
    chk("bad_crc_ready", 32'(ready_cnt), 0);
    chk("bad_crc_error", 32'(rx_error), 1);
    chk("bad_crc_packet", 32'(rx_packet), 0);

    // Bad PID check nibble
    clr();
    tx_q = '{8'h33, 8'h12, 8'h34};
    send_head();
    chk("bad_pid_error", 32'(rx_error), 1);
    chk("bad_pid_active_mid", 32'(rx_transfer_active), 1);
    send_eop();
    chk("bad_pid_active_end", 32'(rx_transfer_active), 0);
    chk("bad_pid_packet", 32'(rx_packet), 0);
    chk("bad_pid_stores", 32'(store_cnt), 0);

    // Overflow on DATA1, then a clean IN token
    clr();
    buffer_occupancy = 7'd64;
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_data(8'h4B, 1'b0, 1'b0);
    send_head();
    send_eop();
    chk("ovf_stores", 32'(store_cnt), 0);
    chk("ovf_error", 32'(rx_error), 1);
    chk("ovf_ready", 32'(ready_cnt), 0);
    chk("ovf_active", 32'(rx_transfer_active), 0);
    buffer_occupancy = 7'd0;
    clr();
    tx_q = '{8'h69, 8'h81, 8'h58};
    send_head();
    chk("in_error_cleared", 32'(rx_error), 0);
    chk("in_active_mid", 32'(rx_transfer_active), 1);
    send_eop();
    chk("in_packet", 32'(rx_packet), 2);
    chk("in_active_end", 32'(rx_transfer_active), 0);

    // Reset in the middle of data byte 3
    clr();
    tx_q = '{8'hC3, 8'h5A, 8'hA5};
    send_head();
    b3 = 8'h55;
    for (int i = 0; i < 4; i++) send_bit(b3[i]);
    @(posedge clk);
    #1 n_rst = 1'b0;
    dplus_in  = 1'b1;
    dminus_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_packet", 32'(rx_packet), 0);
    chk("mid_rst_outs", 32'({rx_data_ready, rx_transfer_active, rx_error,
                             flush, store_rx_packet_data}), 0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (4) hold(1'b1, 1'b0);
    chk("mid_rst_stores", 32'(store_cnt), 0);
    clr();
    pay_q = '{8'h11, 8'h22};
    load_data(8'h4B, 1'b0, 1'b1);
    send_head();
    send_eop();
    chk("after_rst_stores", 32'(store_cnt), 2);
    chk("after_rst_pending", 32'(exp_q.size()), 0);
    chk("after_rst_packet", 32'(rx_packet), 4);
    chk("after_rst_ready", 32'(ready_cnt), 1);
    chk("after_rst_error", 32'(rx_error), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
